// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, funct codes, state encodings, ALU codes and per-state control decode for mc_controller.
package mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin c.irwrite = 1'b1; c.alusrcb = 2'b01; c.pcwrite = 1'b1; end
      DECODE: c.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD: c.iord = 1'b1;
      MEMWR: begin c.iord = 1'b1; c.memwrite = 1'b1; end
      MEMWB: begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      EXEC: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      ALUWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BRANCH: begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      ADDIWB: c.regwrite = 1'b1;
      JUMP: begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp and Funct to the ALU control code.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);
  always_comb
    alu_control = aluop == 2'b01 ? ALU_SUB :
                  aluop != 2'b10 ? ALU_ADD :
                  funct == F_SUB ? ALU_SUB :
                  funct == F_AND ? ALU_AND :
                  funct == F_OR  ? ALU_OR  :
                  funct == F_SLT ? ALU_SLT : ALU_ADD;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS Moore control FSM with registered per-state controls.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State
);
  state_t state, nxt;
  ctrl_t ctl;
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH: nxt = DECODE;
      DECODE: nxt = (Op == OP_LW || Op == OP_SW) ? MEMADR :
                    Op == OP_RTYPE ? EXEC :
                    Op == OP_BEQ   ? BRANCH :
                    Op == OP_ADDI  ? ADDIEX :
                    Op == OP_J     ? JUMP : FETCH;
      MEMADR: nxt = Op == OP_SW ? MEMWR : MEMRD;
      MEMRD: nxt = MEMWB;
      EXEC: nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end
  // controls are decoded from the next state so they change together with State
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= FETCH;
      ctl <= decode(FETCH);
    end else begin
      state <= nxt;
      ctl <= decode(nxt);
    end
  alu_decoder u_dec (
    .aluop(ctl.aluop),
    .funct(Funct),
    .alu_control(ALUControl)
  );
  assign IorD = ctl.iord;
  assign MemWrite = ctl.memwrite;
  assign IRWrite = ctl.irwrite;
  assign RegDst = ctl.regdst;
  assign MemtoReg = ctl.memtoreg;
  assign RegWrite = ctl.regwrite;
  assign ALUSrcA = ctl.alusrca;
  assign ALUSrcB = ctl.alusrcb;
  assign PCSrc = ctl.pcsrc;
  assign PCEn = ctl.pcwrite | (ctl.branch & Zero);
  assign State = state;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: random instruction streams with mid-instruction resets, checked by a queue scoreboard.
module tb_mc_controller;
  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] Op, Funct;
  logic Zero;
  logic IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
  typedef logic [18:0] obs_t;
  typedef int iq_t[$];
  obs_t q[$];
  int total = 0, bad = 0, cyc = 0;

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .State(State)
  );

  always #5 clk = ~clk;

  // observation layout: state, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, alucontrol, pcsrc, pcen
  function automatic obs_t expect_obs(int s, logic [5:0] fn, logic z);
    logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pcen = 0;
    logic [1:0] sb = 2'b00, pcs = 2'b00;
    logic [2:0] alu = 3'b010;
    case (s)
      0: begin irw = 1; sb = 2'b01; pcen = 1; end
      1: sb = 2'b11;
      2, 9: begin sa = 1; sb = 2'b10; end
      3: iord = 1;
      4: begin m2r = 1; rw = 1; end
      5: begin iord = 1; mw = 1; end
      6: begin
        sa = 1;
        alu = fn == 6'b100010 ? 3'b110 : fn == 6'b100100 ? 3'b000 :
              fn == 6'b100101 ? 3'b001 : fn == 6'b101010 ? 3'b111 : 3'b010;
      end
      7: begin rd = 1; rw = 1; end
      8: begin sa = 1; alu = 3'b110; pcs = 2'b01; pcen = z; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {4'(s), iord, mw, irw, rd, m2r, rw, sa, sb, alu, pcs, pcen};
  endfunction

  function automatic iq_t path(logic [5:0] op);
    case (op)
      6'b100011: return '{0, 1, 2, 3, 4};
      6'b101011: return '{0, 1, 2, 5};
      6'b000000: return '{0, 1, 6, 7};
      6'b000100: return '{0, 1, 8};
      6'b001000: return '{0, 1, 9, 10};
      6'b000010: return '{0, 1, 11};
      default:   return '{0, 1};
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    logic [5:0] fs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    int k = $urandom_range(0, 5);
    return k == 5 ? 6'($urandom) : fs[k];
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] o;
    int k = $urandom_range(0, 6);
    if (k < 6) return ops[k];
    do o = ($urandom_range(0, 3) == 0) ? 6'b111111 : 6'($urandom);
    while (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
    return o;
  endfunction

  // drive one cycle for a DUT sitting in state s, then advance past the next edge
  task automatic step(input int s, input logic r, input logic [5:0] op);
    logic [5:0] fn = pick_funct();
    logic z = 1'($urandom);
    rst_n = r;
    Op = (s == 1 || s == 2) ? op : 6'($urandom);
    Funct = fn;
    Zero = z;
    q.push_back(expect_obs(s, fn, z));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t act, exp_o;
    cyc++;
    if (q.size() != 0) begin
      exp_o = q.pop_front();
      act = {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, ALUControl, PCSrc, PCEn};
      total++;
      if (act !== exp_o) begin
        bad++;
        $display("FAIL cycle%0d outputs: got %b want %b", cyc, act, exp_o);
      end
    end
  end

  initial begin
    iq_t p;
    logic [5:0] op;
    int cut;
    rst_n = 1'b0;
    Op = 6'b100011;
    Funct = '0;
    Zero = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1'b0, 6'b100011);
    for (int n = 0; n < 200; n++) begin
      op = pick_op();
      p = path(op);
      cut = ($urandom_range(0, 7) == 0) ? $urandom_range(0, p.size() - 1) : -1;
      for (int i = 0; i < p.size(); i++) begin
        step(p[i], i == cut ? 1'b0 : 1'b1, op);
        if (i == cut) begin
          if ($urandom_range(0, 1) == 1) step(0, 1'b0, op);
          break;
        end
      end
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset, with ports clk and rst_n.
REQ-002 SHALL expose these ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- Op  in  6  instruction opcode, Instr[31:26].
- Funct  in  6  function field, Instr[5:0].
- Zero  in  1  ALU Zero flag.
- IorD  out  1  memory address select (0 PC, 1 ALUOut).
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  destination select (0 rt, 1 rd).
- MemtoReg  out  1  writeback select (0 ALUOut, 1 Data).
- RegWrite  out  1  register-file write strobe.
- ALUSrcA  out  1  ALU A select (0 PC, 1 register A).
- ALUSrcB  out  2  ALU B select (00 reg B, 01 constant 4, 10 SignImm, 11 SignImm<<2).
- ALUControl  out  3  operation code driven to the ALU Control input.
- PCSrc  out  2  next-PC select (00 ALUResult, 01 ALUOut, 10 jump target).
- PCEn  out  1  PC register enable.
- State  out  4  current state, for debug.

Function
REQ-003 SHALL implement a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-004 SHALL make the following transitions, one state per clock:
- FETCH->DECODE.
- DECODE->MEMADR for lw (100011) or sw (101011).
- DECODE->EXEC for R-type (000000).
- DECODE->BRANCH for beq (000100).
- DECODE->ADDIEX for addi (001000).
- DECODE->JUMP for j (000010).
- DECODE->FETCH for any other Op.
- MEMADR->MEMRD for lw; MEMADR->MEMWR for sw.
- MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all go to FETCH.
- Encodings 12-15 go to FETCH.
REQ-005 SHALL drive every output except PCEn and ALUControl from the state alone. Any output not listed for a state is 0.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMRD: IorD=1.
- MEMWR: IorD=1, MemWrite=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
- JUMP: PCSrc=10, PCWrite=1.
REQ-006 SHALL compute PCEn combinationally as PCWrite OR (Branch AND Zero), so Zero is sampled in the same cycle it is produced.
REQ-007 SHALL map ALUOp to ALUControl as follows:
- ALUOp 00 -> 010 (add).
- ALUOp 01 -> 110 (subtract).
- ALUOp 11 -> 010.
REQ-008 SHALL, for ALUOp 10, map Funct to ALUControl as follows:
- 100000 -> 010 (add).
- 100010 -> 110 (subtract).
- 100100 -> 000 (and).
- 100101 -> 001 (or).
- 101010 -> 111 (set-less-than).
- any other Funct -> 010.
REQ-009 SHALL sample Op only in DECODE and MEMADR. Op changes in other states SHALL have no effect.
REQ-010 SHALL take these cycle counts per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.

Reset
REQ-011 SHALL, when rst_n=0 at a rising clk edge, load State=FETCH, overriding any pending transition, including mid-instruction.
REQ-012 SHALL, while reset is held, present FETCH outputs: IRWrite=1, PCEn=1, ALUControl=010, all write strobes other than IRWrite 0.
REQ-013 SHALL begin fetch at the first edge after rst_n returns to 1, going FETCH->DECODE.

Structure
REQ-014 SHALL place the following in shared package mc_pkg:
- opcode constants;
- Funct constants;
- state encodings;
- ALUControl codes (010, 110, 000, 001, 111).
REQ-015 SHALL contain the combinational sub-module alu_decoder, which maps (ALUOp, Funct) to ALUControl. The state register and next-state/output logic SHALL live in mc_controller.

Verification
REQ-016 Reset: hold rst_n=0 for 2 cycles with Op=100011 -> State=0, IRWrite=1, PCEn=1, MemWrite=0, RegWrite=0.
REQ-017 lw: Op=100011 -> State sequence 0,1,2,3,4. MEMRD has IorD=1; MEMWB has RegWrite=1 and MemtoReg=1.
REQ-018 R-type: Op=000000 with each Funct 100000/100010/100100/100101/101010 -> EXEC ALUControl = 010/110/000/001/111 respectively; ALUWB has RegDst=1.
REQ-019 beq: Op=000100 -> BRANCH with ALUControl=110. Zero=1 gives PCEn=1 and PCSrc=01; Zero=0 gives PCEn=0. Next state is 0 in both cases.
REQ-020 sw, then Op=111111, then reset: sw gives MemWrite=1 only in state 5. Op=111111 returns 1->0 with no strobes. rst_n=0 asserted in state 3 forces State=0 on the next edge.
